// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/Func values, ALU control encodings and the
// control bundle carried through the decode FIFO.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'b1010;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1110;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // The raw 16-bit immediate plus an extension mode keeps the FIFO entry
  // independent of IMM_W; extension happens at the output.
  typedef struct packed {
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic [3:0]  alu_cntl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        imm_zext;
    logic        illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch/execute-facing handshake and decoded-bundle signals of the decode stage.
interface instr_decode_stage_if #(
  parameter int IMM_W     = 32,
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic                 RegWrite;
  logic                 RegDst;
  logic                 ALUSrc;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 MemtoReg;
  logic                 Branch;
  logic [3:0]           ALUCntl;
  logic [4:0]           rs;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic [IMM_W-1:0]     imm;
  logic                 illegal;
  logic [ILL_CNT_W-1:0] ill_count;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, RegWrite, RegDst, ALUSrc, MemRead, MemWrite,
           MemtoReg, Branch, ALUCntl, rs, rt, rd, imm, illegal, ill_count
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, RegWrite, RegDst, ALUSrc, MemRead, MemWrite,
           MemtoReg, Branch, ALUCntl, rs, rt, rd, imm, illegal, ill_count
  );
endinterface

// File: rtl/instr_decode_stage_decoder.sv
// Combinational MIPS decoder: instruction word to ctrl_bundle_t.
// I-type decode is compiled in only when DECODE_ITYPE_EN is defined.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t bundle_o
);
  logic [5:0] op;
  logic [5:0] func;

  assign op   = instr_i[31:26];
  assign func = instr_i[5:0];

  always_comb begin
    bundle_o     = '0;
    bundle_o.rs  = instr_i[25:21];
    bundle_o.rt  = instr_i[20:16];
    bundle_o.rd  = instr_i[15:11];
    bundle_o.imm = instr_i[15:0];
    case (op)
      OP_RTYPE: begin
        bundle_o.reg_write = 1'b1;
        bundle_o.reg_dst   = 1'b1;
        case (func)
          FN_ADD:  bundle_o.alu_cntl = ALU_ADD;
          FN_ADDU: bundle_o.alu_cntl = ALU_ADDU;
          FN_SUB:  bundle_o.alu_cntl = ALU_SUB;
          FN_SUBU: bundle_o.alu_cntl = ALU_SUBU;
          FN_AND:  bundle_o.alu_cntl = ALU_AND;
          FN_OR:   bundle_o.alu_cntl = ALU_OR;
          FN_XOR:  bundle_o.alu_cntl = ALU_XOR;
          FN_NOR:  bundle_o.alu_cntl = ALU_NOR;
          FN_SLT:  bundle_o.alu_cntl = ALU_SLT;
          FN_SLTU: bundle_o.alu_cntl = ALU_SLTU;
          default: begin
            bundle_o.reg_write = 1'b0;
            bundle_o.reg_dst   = 1'b0;
            bundle_o.illegal   = 1'b1;
          end
        endcase
      end
`ifdef DECODE_ITYPE_EN
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        bundle_o.reg_write = 1'b1;
        bundle_o.alu_src   = 1'b1;
        bundle_o.imm_zext  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        case (op)
          OP_ADDI:  bundle_o.alu_cntl = ALU_ADD;
          OP_ADDIU: bundle_o.alu_cntl = ALU_ADDU;
          OP_SLTI:  bundle_o.alu_cntl = ALU_SLT;
          OP_SLTIU: bundle_o.alu_cntl = ALU_SLTU;
          OP_ANDI:  bundle_o.alu_cntl = ALU_AND;
          OP_ORI:   bundle_o.alu_cntl = ALU_OR;
          default:  bundle_o.alu_cntl = ALU_XOR;
        endcase
      end
      OP_LW: begin
        bundle_o.alu_cntl   = ALU_ADDU;
        bundle_o.alu_src    = 1'b1;
        bundle_o.mem_read   = 1'b1;
        bundle_o.mem_to_reg = 1'b1;
        bundle_o.reg_write  = 1'b1;
      end
      OP_SW: begin
        bundle_o.alu_cntl  = ALU_ADDU;
        bundle_o.alu_src   = 1'b1;
        bundle_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        bundle_o.alu_cntl = ALU_SUB;
        bundle_o.branch   = 1'b1;
      end
`endif
      default: bundle_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry valid/ready FIFO plus a
// saturating illegal-instruction counter. Optional I-type decode: DECODE_ITYPE_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int IMM_W     = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus
);
  ctrl_bundle_t         dec_b;
  ctrl_bundle_t         head_b;
  ctrl_bundle_t         mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 push;
  logic                 pop;

  instr_decoder u_decoder (
    .instr_i  (bus.in_instr),
    .bundle_o (dec_b)
  );

  assign bus.in_ready  = (count_q != 2'd2) && !flush;
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
    // push already excludes flush cycles, so flushed illegals are still counted once accepted
    if (push && dec_b.illegal && (ill_cnt_q != '1))
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        mem_q[gi] <= '0;
      else if (push && (wr_ptr_q == 1'(gi)))
        mem_q[gi] <= dec_b;
    end
  end

  assign head_b        = mem_q[rd_ptr_q];
  assign bus.RegWrite  = head_b.reg_write;
  assign bus.RegDst    = head_b.reg_dst;
  assign bus.ALUSrc    = head_b.alu_src;
  assign bus.MemRead   = head_b.mem_read;
  assign bus.MemWrite  = head_b.mem_write;
  assign bus.MemtoReg  = head_b.mem_to_reg;
  assign bus.Branch    = head_b.branch;
  assign bus.ALUCntl   = head_b.alu_cntl;
  assign bus.rs        = head_b.rs;
  assign bus.rt        = head_b.rt;
  assign bus.rd        = head_b.rd;
  assign bus.illegal   = head_b.illegal;
  assign bus.ill_count = ill_cnt_q;

  if (IMM_W > 16) begin : g_imm_ext
    assign bus.imm = {{(IMM_W-16){head_b.imm_zext ? 1'b0 : head_b.imm[15]}}, head_b.imm};
  end else begin : g_imm_raw
    assign bus.imm = head_b.imm;
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; I-type checks follow DECODE_ITYPE_EN.
module tb_instr_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   exp_ill = 0;
  logic [6:0] ctl;

  instr_decode_stage_if #(.IMM_W(32), .ILL_CNT_W(2)) bus ();

  instr_decode_stage #(.IMM_W(32), .ILL_CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RegWrite RegDst ALUSrc MemRead MemWrite MemtoReg Branch
  assign ctl = {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.MemRead,
                bus.MemWrite, bus.MemtoReg, bus.Branch};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, bus.ill_count} !== {1'b0, 1'b1, 2'd0}) begin
      err_cnt++;
      $display("FAIL reset_hs: out_valid/in_ready/ill_count got %b%b/%0d want 01/0", bus.out_valid, bus.in_ready, bus.ill_count);
    end
    vec_cnt++;
    if ({ctl, bus.ALUCntl, bus.imm, bus.illegal} !== '0) begin
      err_cnt++;
      $display("FAIL reset_bundle: ctl=%b alu=%b imm=%h ill=%b want all 0", ctl, bus.ALUCntl, bus.imm, bus.illegal);
    end
    $display("reset: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] funcs [10];
    logic [3:0] alus  [10];
    funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    alus  = '{4'b1010, 4'b0010, 4'b1110, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b1111};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = {26'h004A900, funcs[i]} & 32'hFFFF_FFFF;
      bus.in_instr = 32'h012A4000 | {26'h0, funcs[i]};
      tick();
      vec_cnt++;
      if ({bus.out_valid, ctl, bus.ALUCntl, bus.illegal, bus.rs, bus.rt, bus.rd} !==
          {1'b1, 7'b1100000, alus[i], 1'b0, 5'd9, 5'd10, 5'd8}) begin
        err_cnt++;
        $display("FAIL rtype_%h: v=%b ctl=%b alu=%b ill=%b rs/rt/rd=%0d/%0d/%0d want v=1 ctl=1100000 alu=%b ill=0 9/10/8",
                 funcs[i], bus.out_valid, ctl, bus.ALUCntl, bus.illegal, bus.rs, bus.rt, bus.rd, alus[i]);
      end
      $display("rtype func=%h alu=%b", funcs[i], bus.ALUCntl);
    end
    vec_cnt++;
    if (bus.imm !== 32'h0000402B) begin
      err_cnt++;
      $display("FAIL rtype_imm: got %h want 0000402b", bus.imm);
    end
    bus.in_valid = 1'b0;
    tick();
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rtype_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_itype();
    logic [31:0] ins  [5];
    logic [6:0]  ectl [5];
    logic [3:0]  ealu [5];
    logic [31:0] eimm [5];
    logic        eill [5];
    ins = '{32'h8D090004, 32'h3509FFFF, 32'h2109FFFF, 32'hAD090004, 32'h11090003};
`ifdef DECODE_ITYPE_EN
    ectl = '{7'b1011010, 7'b1010000, 7'b1010000, 7'b0010100, 7'b0000001};
    ealu = '{4'b0010, 4'b0001, 4'b1010, 4'b0010, 4'b1110};
    eimm = '{32'h00000004, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00000004, 32'h00000003};
    eill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    ectl = '{7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
    ealu = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    eimm = '{32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000004, 32'h00000003};
    eill = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = ins[i];
      tick();
      if (eill[i] && exp_ill < 3) exp_ill++;
      vec_cnt++;
      if ({bus.out_valid, ctl, bus.ALUCntl, bus.imm, bus.illegal, bus.ill_count} !==
          {1'b1, ectl[i], ealu[i], eimm[i], eill[i], 2'(exp_ill)}) begin
        err_cnt++;
        $display("FAIL itype_%h: v=%b ctl=%b alu=%b imm=%h ill=%b cnt=%0d want v=1 ctl=%b alu=%b imm=%h ill=%b cnt=%0d",
                 ins[i], bus.out_valid, ctl, bus.ALUCntl, bus.imm, bus.illegal, bus.ill_count,
                 ectl[i], ealu[i], eimm[i], eill[i], exp_ill);
      end
      $display("itype instr=%h ctl=%b alu=%b imm=%h", ins[i], ctl, bus.ALUCntl, bus.imm);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A0820;  // add rd=1
    tick();
    bus.in_instr  = 32'h012A1022;  // sub rd=2
    tick();
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, bus.rd} !== {1'b1, 1'b0, 5'd1}) begin
      err_cnt++;
      $display("FAIL bp_full: v/rdy/rd got %b/%b/%0d want 1/0/1", bus.out_valid, bus.in_ready, bus.rd);
    end
    bus.in_instr  = 32'h012A1825;  // or rd=3, held off while full
    tick();
    vec_cnt++;
    if ({bus.in_ready, bus.rd, bus.ALUCntl} !== {1'b0, 5'd1, 4'b1010}) begin
      err_cnt++;
      $display("FAIL bp_hold: rdy/rd/alu got %b/%0d/%b want 0/1/1010", bus.in_ready, bus.rd, bus.ALUCntl);
    end
    bus.out_ready = 1'b1;
    tick();
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, bus.rd, bus.ALUCntl} !== {1'b1, 1'b1, 5'd2, 4'b1110}) begin
      err_cnt++;
      $display("FAIL bp_pop1: v/rdy/rd/alu got %b/%b/%0d/%b want 1/1/2/1110", bus.out_valid, bus.in_ready, bus.rd, bus.ALUCntl);
    end
    tick();
    vec_cnt++;
    if ({bus.out_valid, bus.rd, bus.ALUCntl} !== {1'b1, 5'd3, 4'b0001}) begin
      err_cnt++;
      $display("FAIL bp_pop2: v/rd/alu got %b/%0d/%b want 1/3/0001", bus.out_valid, bus.rd, bus.ALUCntl);
    end
    bus.in_valid = 1'b0;
    tick();
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_dup: out_valid got %b want 0", bus.out_valid);
    end
    $display("backpressure: three instructions drained in order");
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A0820;
    tick();
    tick();
    flush = 1'b1;
    bus.in_instr = 32'h012A1825;
    #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_rdy: in_ready got %b want 0", bus.in_ready);
    end
    tick();
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL flush_empty: v/rdy got %b/%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_emit: out_valid got %b want 0", bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h012A1022;
    tick();
    bus.in_valid = 1'b0;
    vec_cnt++;
    if ({bus.out_valid, bus.rd, bus.ALUCntl} !== {1'b1, 5'd2, 4'b1110}) begin
      err_cnt++;
      $display("FAIL flush_resume: v/rd/alu got %b/%0d/%b want 1/2/1110", bus.out_valid, bus.rd, bus.ALUCntl);
    end
    tick();
    $display("flush: buffer emptied, decode resumed");
  endtask

  task automatic test_illegal();
    logic [31:0] ins [5];
    ins = '{32'hFC000000, 32'h012A403F, 32'hFC000000, 32'h012A403F, 32'h012A4000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = ins[i];
      tick();
      if (exp_ill < 3) exp_ill++;
      vec_cnt++;
      if ({bus.out_valid, bus.illegal, ctl, bus.ALUCntl, bus.ill_count} !==
          {1'b1, 1'b1, 7'b0, 4'b0, 2'(exp_ill)}) begin
        err_cnt++;
        $display("FAIL illegal_%0d: v=%b ill=%b ctl=%b alu=%b cnt=%0d want v=1 ill=1 ctl=0 alu=0 cnt=%0d",
                 i, bus.out_valid, bus.illegal, ctl, bus.ALUCntl, bus.ill_count, exp_ill);
      end
      $display("illegal instr=%h ill_count=%0d", ins[i], bus.ill_count);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFC000000;
    tick();
    bus.in_instr  = 32'h012A0820;
    tick();
    reset = 1'b1;
    #1;
    exp_ill = 0;
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, bus.ill_count, ctl, bus.ALUCntl, bus.illegal} !==
        {1'b0, 1'b1, 2'd0, 7'b0, 4'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL rst_mid: v/rdy/cnt/ctl/alu/ill got %b/%b/%0d/%b/%b/%b want 0/1/0/0/0/0",
               bus.out_valid, bus.in_ready, bus.ill_count, ctl, bus.ALUCntl, bus.illegal);
    end
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A4020;
    tick();
    bus.in_valid = 1'b0;
    vec_cnt++;
    if ({bus.out_valid, ctl, bus.ALUCntl, bus.ill_count} !== {1'b1, 7'b1100000, 4'b1010, 2'd0}) begin
      err_cnt++;
      $display("FAIL rst_resume: v/ctl/alu/cnt got %b/%b/%b/%0d want 1/1100000/1010/0",
               bus.out_valid, ctl, bus.ALUCntl, bus.ill_count);
    end
    $display("reset mid-stream: decode resumed alu=%b", bus.ALUCntl);
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype_sweep();
    test_itype();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
